serial_pattern_tx: RTL and testbench

//  Transmit side of the serial 'x' bit stream that our Moore sequence detectors consume.

---
 rtl/serial_tx_pkg.sv | 14 +
 rtl/tx_bit_counter.sv | 39 +++
 rtl/serial_pattern_tx.sv | 195 +++++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10,
        DONE  = 2'b11
    } tx_state_t;

    // Level driven on x whenever no frame bit is being sent.
    localparam logic IDLE_X = 1'b0;

endpackage

// File: rtl/tx_bit_counter.sv
// Saturating bit counter: clears on clr, counts on en, stops at maxval.
module tx_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] maxval,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Next count: clear has priority, increment only below the ceiling.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && (count_reg != maxval)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Count register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == maxval);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a word over valid/ready and shifts it
// out one bit per clock on x, qualified by x_valid, with a done pulse after
// the last bit. Define SERIAL_TX_PARITY_EN to append an even parity bit.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [SIZE-1:0] load_data,
    input  logic            abort,
    output logic            x,
    output logic            x_valid,
    output logic            busy,
    output logic            done
);

    localparam int              CNT_W     = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(SIZE - 1);
    // Bit position that is on x while shifting.
    localparam int              HEAD_IDX  = (MSB_FIRST != 0) ? SIZE - 1 : 0;

    tx_state_t        state_reg;
    tx_state_t        state_next;
    logic [SIZE-1:0]  shift_data_reg;
    logic [SIZE-1:0]  shift_data_next;
    logic [SIZE-1:0]  shifted_data;
    logic [CNT_W-1:0] bit_count;
    logic             bit_at_max;
    logic             accept;
    logic             shifting;
    logic             last_bit;

    assign accept   = (state_reg == IDLE) && load_valid;
    assign shifting = (state_reg == SHIFT);
    assign last_bit = (bit_count == MAX_COUNT);

    // Word moved one place toward the head; the vacated end fills with zero.
    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted_data[gi] = 1'b0;
                end else begin : g_move
                    assign shifted_data[gi] = shift_data_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == SIZE - 1) begin : g_fill
                    assign shifted_data[gi] = 1'b0;
                end else begin : g_move
                    assign shifted_data[gi] = shift_data_reg[gi+1];
                end
            end
        end
    endgenerate

    // Bit index within the frame; cleared at every accept, held once at the ceiling.
    tx_bit_counter #(
        .WIDTH (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (shifting && !bit_at_max),
        .maxval (MAX_COUNT),
        .count  (bit_count),
        .at_max (bit_at_max)
    );

    // Shift register: capture at the handshake, advance once per SHIFT cycle.
    always_comb begin
        shift_data_next = shift_data_reg;
        if (accept) begin
            shift_data_next = load_data;
        end else if (shifting) begin
            shift_data_next = shifted_data;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_data_reg <= '0;
        end else begin
            shift_data_reg <= shift_data_next;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    logic parity_reg;
    logic parity_next;

    // Even parity of the word as it was accepted.
    always_comb begin
        parity_next = parity_reg;
        if (accept) begin
            parity_next = ^load_data;
        end
    end

    // Parity bit storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

    // Next-state logic; a handshake beats abort in IDLE since abort only acts in SHIFT/PAR.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_next = PAR;
`else
                    state_next = DONE;
`endif
                end
            end
            PAR: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Moore output decode from the current state and stored data.
    always_comb begin
        x          = IDLE_X;
        x_valid    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                x       = shift_data_reg[HEAD_IDX];
                x_valid = 1'b1;
                busy    = 1'b1;
            end
            PAR: begin
`ifdef SERIAL_TX_PARITY_EN
                x       = parity_reg;
`else
                x       = IDLE_X;
`endif
                x_valid = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                x = IDLE_X;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three instances (8-bit MSB-first, 8-bit
// LSB-first, 1-bit) checked against a bit scoreboard filled at each handshake.
module tb_serial_pattern_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME8 = 8 + PAR_BITS;
    localparam int FRAME1 = 1 + PAR_BITS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       load_valid_a, load_ready_a, abort_a, x_a, x_valid_a, busy_a, done_a;
    logic [7:0] load_data_a;
    logic       load_valid_b, load_ready_b, abort_b, x_b, x_valid_b, busy_b, done_b;
    logic [7:0] load_data_b;
    logic       load_valid_c, load_ready_c, abort_c, x_c, x_valid_c, busy_c, done_c;
    logic [0:0] load_data_c;

    serial_pattern_tx #(.SIZE(8), .MSB_FIRST(1)) u_dut_a (
        .clk(clk), .reset(reset), .load_valid(load_valid_a), .load_ready(load_ready_a),
        .load_data(load_data_a), .abort(abort_a), .x(x_a), .x_valid(x_valid_a),
        .busy(busy_a), .done(done_a)
    );
    serial_pattern_tx #(.SIZE(8), .MSB_FIRST(0)) u_dut_b (
        .clk(clk), .reset(reset), .load_valid(load_valid_b), .load_ready(load_ready_b),
        .load_data(load_data_b), .abort(abort_b), .x(x_b), .x_valid(x_valid_b),
        .busy(busy_b), .done(done_b)
    );
    serial_pattern_tx #(.SIZE(1), .MSB_FIRST(1)) u_dut_c (
        .clk(clk), .reset(reset), .load_valid(load_valid_c), .load_ready(load_ready_c),
        .load_data(load_data_c), .abort(abort_c), .x(x_c), .x_valid(x_valid_c),
        .busy(busy_c), .done(done_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic exp_q_a[$];
    logic exp_q_b[$];
    logic exp_q_c[$];
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;
    int   done_cnt_c = 0;
    int   valid_cnt_c = 0;
    logic [2:0] win_b = 3'b000;
    int   pos_b = 0;
    int   hit_pos_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumers: one per instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (x_valid_a) begin
                if (exp_q_a.size() == 0) check("a_unexpected_bit", 32'd1, 32'd0);
                else check("a_bit", x_a, exp_q_a.pop_front());
            end else begin
                check("a_x_idle", x_a, 1'b0);
            end
            if (done_a) done_cnt_a++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (x_valid_b) begin
                pos_b++;
                win_b = {win_b[1:0], x_b};
                if (pos_b >= 3 && win_b == 3'b101 && hit_pos_b == 0) hit_pos_b = pos_b;
                if (exp_q_b.size() == 0) check("b_unexpected_bit", 32'd1, 32'd0);
                else check("b_bit", x_b, exp_q_b.pop_front());
            end
            if (done_b) done_cnt_b++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (x_valid_c) begin
                valid_cnt_c++;
                if (exp_q_c.size() == 0) check("c_unexpected_bit", 32'd1, 32'd0);
                else check("c_bit", x_c, exp_q_c.pop_front());
            end
            if (done_c) done_cnt_c++;
        end
    end

    task automatic push_a(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) exp_q_a.push_back(d[i]);
        if (PAR_BITS != 0) exp_q_a.push_back(^d);
    endtask

    task automatic load_a(input logic [7:0] d);
        int n = 0;
        while (!load_ready_a && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready_a) begin
            check("a_ready_timeout", 32'd0, 32'd1);
            return;
        end
        load_data_a  = d;
        load_valid_a = 1'b1;
        push_a(d);
        @(posedge clk);
        #1 load_valid_a = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] d);
        int n = 0;
        while (!load_ready_b && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready_b) begin
            check("b_ready_timeout", 32'd0, 32'd1);
            return;
        end
        pos_b = 0;
        win_b = 3'b000;
        hit_pos_b = 0;
        load_data_b  = d;
        load_valid_b = 1'b1;
        for (int i = 0; i < 8; i++) exp_q_b.push_back(d[i]);
        if (PAR_BITS != 0) exp_q_b.push_back(^d);
        @(posedge clk);
        #1 load_valid_b = 1'b0;
    endtask

    // Counts falling edges from just after a handshake until done is seen.
    task automatic wait_done(input int which, input int exp_cycles, input string tag);
        int   n = 0;
        logic d;
        do begin
            @(negedge clk);
            n++;
            d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end while (!d && n < 64);
        check(tag, n, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int done_before;
        int n;
        load_valid_a = 0; load_data_a = '0; abort_a = 0;
        load_valid_b = 0; load_data_b = '0; abort_b = 0;
        load_valid_c = 0; load_data_c = '0; abort_c = 0;

        // Reset values, during and after reset.
        @(negedge clk);
        #1;
        check("rst_x_valid", x_valid_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_load_ready_a", load_ready_a, 1'b1);
        check("rst_load_ready_b", load_ready_b, 1'b1);
        check("rst_load_ready_c", load_ready_c, 1'b1);
        check("rst_x_a", x_a, 1'b0);

        // T1: MSB-first 8'hA5.
        load_a(8'hA5);
        check("t1_first_valid", x_valid_a, 1'b1);
        check("t1_first_bit", x_a, 1'b1);
        check("t1_busy", busy_a, 1'b1);
        check("t1_ready_low", load_ready_a, 1'b0);
        wait_done(0, FRAME8 + 1, "t1_done_cycle");
        @(negedge clk);
        check("t1_done_one_cycle", done_a, 1'b0);
        check("t1_ready_back", load_ready_a, 1'b1);
        check("t1_done_count", done_cnt_a, 1);

        // T3: 8'h07, parity bit (when enabled) is 1.
        load_a(8'h07);
        wait_done(0, FRAME8 + 1, "t3_done_cycle");
        @(negedge clk);

        // T2: LSB-first 8'h05 into a 101 detector.
        load_b(8'h05);
        check("t2_first_bit", x_b, 1'b1);
        wait_done(1, FRAME8 + 1, "t2_done_cycle");
        check("t2_detect_pos", hit_pos_b, 3);
        @(negedge clk);
        check("t2_done_count", done_cnt_b, 1);

        // T4: abort at bit 3 with load_valid held during SHIFT.
        done_before = done_cnt_a;
        load_data_a  = 8'hC3;
        load_valid_a = 1'b1;
        exp_q_a.push_back(1'b1);
        exp_q_a.push_back(1'b1);
        exp_q_a.push_back(1'b0);
        @(posedge clk);
        #1 load_data_a = 8'h5A;
        check("t4_ready_low", load_ready_a, 1'b0);
        repeat (3) @(negedge clk);
        abort_a = 1'b1;
        @(posedge clk);
        #1 abort_a = 1'b0;
        check("t4_abort_x_valid", x_valid_a, 1'b0);
        check("t4_abort_busy", busy_a, 1'b0);
        check("t4_abort_ready", load_ready_a, 1'b1);
        check("t4_abort_no_done", done_a, 1'b0);
        push_a(8'h5A);
        @(posedge clk);
        #1 load_valid_a = 1'b0;
        check("t4_held_accept", x_valid_a, 1'b1);
        wait_done(0, FRAME8 + 1, "t4_held_done");
        @(negedge clk);
        check("t4_done_count", done_cnt_a, done_before + 1);

        // T5: reset mid-frame, then 8'hFF.
        load_a(8'h3C);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_x", x_a, 1'b0);
        check("t5_rst_x_valid", x_valid_a, 1'b0);
        check("t5_rst_busy", busy_a, 1'b0);
        check("t5_rst_done", done_a, 1'b0);
        exp_q_a.delete();
        done_before = done_cnt_a;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("t5_ready_after_rst", load_ready_a, 1'b1);
        load_a(8'hFF);
        wait_done(0, FRAME8 + 1, "t5_ff_done");
        @(negedge clk);
        check("t5_done_count", done_cnt_a, done_before + 1);

        // T6: SIZE=1 back-to-back loads 1 then 0.
        valid_cnt_c  = 0;
        load_data_c  = 1'b1;
        load_valid_c = 1'b1;
        exp_q_c.push_back(1'b1);
        if (PAR_BITS != 0) exp_q_c.push_back(1'b1);
        @(posedge clk);
        #1 load_data_c = 1'b0;
        exp_q_c.push_back(1'b0);
        if (PAR_BITS != 0) exp_q_c.push_back(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load_ready_c && n < 32);
        check("t6_second_accept", n, FRAME1 + 2);
        @(posedge clk);
        #1 load_valid_c = 1'b0;
        wait_done(2, FRAME1 + 1, "t6_second_done");
        @(negedge clk);
        check("t6_valid_cycles", valid_cnt_c, 2 * FRAME1);
        check("t6_done_count", done_cnt_c, 2);

        // All scheduled bits consumed.
        check("a_queue_empty", exp_q_a.size(), 0);
        check("b_queue_empty", exp_q_b.size(), 0);
        check("c_queue_empty", exp_q_c.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
